pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//   Parametrised stall/flush controller for the in-order MIPS core, one level above the stage registers.
//   Turns per-stage stall requests into a prefix stall mask and priority-encodes the exception flags.
//   Issues a registered, multi-cycle flush together with the redirect PC.
//   Defers exceptions raised under a global stall. Keeps a saturating stall-cycle performance counter.
// PARAMETERS
//   STAGES        6             number of stall domains; bit 0 = PC, bit STAGES-1 = WB
//   EXC_NUM       7             exception flag count; bit 0 = ERET (highest priority), bit EXC_NUM-1 lowest
//   ADDR_WIDTH    32            width of cp0_epc and exc_pc
//   EXC_VECTOR    32'hbfc00380  redirect target for every non-ERET exception
//   RESET_VECTOR  32'hbfc00000  exc_pc value when no exception is active
//   FLUSH_CYCLES  1             flush pulse length in cycles, >=1
// PORTS
//   clk        in   1                      core clock, rising edge
//   rst        in   1                      reset; asynchronous, active-high
//   stall_req  in   STAGES                 bit i: stage i requests a stall of itself and every earlier stage
//   stall_all  in   1                      freeze the whole pipeline (bus wait)
//   exc_flags  in   EXC_NUM                exception flags from MEM/CP0, sampled every cycle
//   cp0_epc    in   ADDR_WIDTH             EPC value used for ERET
//   stall      out  STAGES                 per-stage stall enables
//   flush      out  1                      flush all stage registers; load exc_pc into PC
//   exc_pc     out  ADDR_WIDTH             redirect PC, valid while flush=1
//   exc_code   out  $clog2(EXC_NUM)        index of the winning flag, valid while flush=1
//   busy       out  1                      state != IDLE
//   stall_cnt  out  32                     cycles with any stall bit set, saturating
// BEHAVIOUR
//   Stall mask (combinational)
//     - h = highest set index of stall_req; stall[h:0]=1, all higher bits 0; stall_req==0 -> stall=0.
//     - stall_all=1 or rst=1 -> stall = all ones.
//     - state FLUSH and stall_all=0 -> stall=0 (flush overrides requests).
//   Exception select (combinational)
//     - w = lowest set index of exc_flags.
//     - target = cp0_epc if w==0, else EXC_VECTOR.
//   FSM states: IDLE, PENDING, FLUSH.
//   IDLE
//     - exc_flags!=0 and stall_all=0: latch w and target, load cnt=FLUSH_CYCLES-1, go to FLUSH.
//     - exc_flags!=0 and stall_all=1: latch w and target, go to PENDING.
//   PENDING
//     - New flags are ignored; the first latch wins.
//     - stall_all=0: load cnt, go to FLUSH.
//   FLUSH
//     - flush=1; exc_pc and exc_code = latched values.
//     - stall_all=1: cnt frozen, flush held.
//     - Otherwise cnt==0 -> IDLE, else cnt decrements.
//     - Flags arriving in FLUSH are discarded.
//   Latency: exception sampled at edge T with stall_all=0 -> flush high for cycles T+1 .. T+FLUSH_CYCLES.
//   Outputs when not in FLUSH: flush=0, exc_pc=RESET_VECTOR, exc_code=0.
//   stall_cnt: +1 on each edge where |stall=1; holds at 32'hFFFFFFFF.
//   Reset (asserts asynchronously, mid-operation included)
//     - state=IDLE, flush=0, exc_pc=RESET_VECTOR, exc_code=0, busy=0, stall_cnt=0.
//     - Any pending or active flush is dropped.
//   Simultaneous stall_req and exception in IDLE: stall follows stall_req in that cycle; flush follows next cycle.
// TESTING
//   1. stall_req=6'b000100 -> stall=6'b000111; stall_req=6'b001010 -> stall=6'b001111; stall_all=1 -> 6'b111111.
//   2. exc_flags=7'b0000001, cp0_epc=32'h80001234 at edge T -> flush=1 and exc_pc=32'h80001234 at T+1 only; exc_code=0.
//   3. exc_flags=7'b0100100 -> exc_code=2, exc_pc=32'hbfc00380; a new flag during the flush cycle produces no second flush.
//   4. Exception with stall_all=1 for 3 cycles -> busy=1, flush=0 until stall_all falls, then flush for 1 cycle.
//   5. FLUSH_CYCLES=3, stall_all pulses in cycle 2 of the flush -> flush high for 4 cycles total.
//   6. rst asserted mid-FLUSH -> flush=0 and exc_pc=32'hbfc00000 immediately, stall_cnt=0; a counter preloaded near max saturates at 32'hFFFFFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the core's stage logic and the hazard controller.
// The core side drives requests and exception flags; the controller returns stall/flush/redirect.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned STAGES     = 6,
  parameter int unsigned EXC_NUM    = 7,
  parameter int unsigned ADDR_WIDTH = 32
);
  localparam int unsigned CODE_W = (EXC_NUM > 1) ? $clog2(EXC_NUM) : 1;

  logic [STAGES-1:0]     stall_req;
  logic                  stall_all;
  logic [EXC_NUM-1:0]    exc_flags;
  logic [ADDR_WIDTH-1:0] cp0_epc;
  logic [STAGES-1:0]     stall;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] exc_pc;
  logic [CODE_W-1:0]     exc_code;
  logic                  busy;
  logic [31:0]           stall_cnt;

  modport master (
    output stall_req, stall_all, exc_flags, cp0_epc,
    input  stall, flush, exc_pc, exc_code, busy, stall_cnt
  );

  modport slave (
    input  stall_req, stall_all, exc_flags, cp0_epc,
    output stall, flush, exc_pc, exc_code, busy, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: prefix stall mask, prioritised exception redirect with
// deferral under global stall, multi-cycle registered flush and a saturating stall counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned           STAGES       = 6,
  parameter int unsigned           EXC_NUM      = 7,
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR   = 'hbfc00380,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 'hbfc00000,
  parameter int unsigned           FLUSH_CYCLES = 1
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int unsigned CODE_W = (EXC_NUM > 1) ? $clog2(EXC_NUM) : 1;
  localparam int unsigned CNT_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, PENDING, FLUSH} state_e;

  state_e                state_q, state_d;
  logic [CODE_W-1:0]     code_q, code_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           stall_cnt_q, stall_cnt_d;

  logic [STAGES-1:0]     req_mask;
  logic [STAGES-1:0]     stall;
  logic [CODE_W-1:0]     win_code;
  logic [ADDR_WIDTH-1:0] win_pc;
  logic                  any_exc;

  // Stage i stalls when it or any later stage requests: suffix-OR from the top down.
  always_comb begin
    logic acc;
    acc      = 1'b0;
    req_mask = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      acc                      = acc | bus.stall_req[STAGES-1-i];
      req_mask[STAGES-1-i]     = acc;
    end
  end

  always_comb begin
    stall = req_mask;
    if (rst || bus.stall_all)
      stall = '1;
    else if (state_q == FLUSH)
      stall = '0;
  end

  // Scanning downward leaves the lowest set flag as the winner.
  always_comb begin
    win_code = '0;
    for (int unsigned i = 0; i < EXC_NUM; i++) begin
      if (bus.exc_flags[EXC_NUM-1-i])
        win_code = CODE_W'(EXC_NUM-1-i);
    end
    win_pc  = (win_code == '0) ? bus.cp0_epc : EXC_VECTOR;
    any_exc = |bus.exc_flags;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_exc) begin
          code_d = win_code;
          pc_d   = win_pc;
          if (bus.stall_all) begin
            state_d = PENDING;
          end else begin
            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
            state_d = FLUSH;
          end
        end
      end
      PENDING: begin
        if (!bus.stall_all) begin
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!bus.stall_all) begin
          if (cnt_q == '0)
            state_d = IDLE;
          else
            cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (|stall && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      code_q      <= '0;
      pc_q        <= RESET_VECTOR;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.flush     = (state_q == FLUSH);
  assign bus.exc_pc    = (state_q == FLUSH) ? pc_q : RESET_VECTOR;
  assign bus.exc_code  = (state_q == FLUSH) ? code_q : '0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl: one instance with single-cycle
// flush and one with a three-cycle flush, sharing clock and reset.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.STAGES(6), .EXC_NUM(7), .ADDR_WIDTH(32)) bus1 ();
  pipeline_hazard_ctrl_if #(.STAGES(6), .EXC_NUM(7), .ADDR_WIDTH(32)) bus3 ();

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus1.stall_req = '0; bus1.stall_all = 1'b0; bus1.exc_flags = '0; bus1.cp0_epc = '0;
    bus3.stall_req = '0; bus3.stall_all = 1'b0; bus3.exc_flags = '0; bus3.cp0_epc = '0;

    // Reset state
    #1;
    check("rst_stall",  64'(bus1.stall),     64'h3f);
    check("rst_flush",  64'(bus1.flush),     64'h0);
    check("rst_pc",     64'(bus1.exc_pc),    64'hbfc00000);
    check("rst_code",   64'(bus1.exc_code),  64'h0);
    check("rst_busy",   64'(bus1.busy),      64'h0);
    check("rst_cnt",    64'(bus1.stall_cnt), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_stall", 64'(bus1.stall), 64'h0);

    // Stall mask
    @(negedge clk);
    bus1.stall_req = 6'b000100; #1;
    check("mask_100", 64'(bus1.stall), 64'h07);
    @(negedge clk);
    bus1.stall_req = 6'b001010; #1;
    check("mask_1010", 64'(bus1.stall), 64'h0f);
    @(negedge clk);
    bus1.stall_req = 6'b000000; bus1.stall_all = 1'b1; #1;
    check("mask_all", 64'(bus1.stall), 64'h3f);
    @(negedge clk);
    bus1.stall_req = 6'b100000; bus1.stall_all = 1'b0; #1;
    check("mask_top", 64'(bus1.stall), 64'h3f);
    @(negedge clk);
    bus1.stall_req = 6'b000001; #1;
    check("mask_bot", 64'(bus1.stall), 64'h01);
    @(negedge clk);
    bus1.stall_req = '0; #1;
    check("mask_none", 64'(bus1.stall), 64'h0);
    check("cnt_after_mask", 64'(bus1.stall_cnt), 64'd5);

    // ERET: redirect to EPC for exactly one cycle
    @(negedge clk);
    bus1.exc_flags = 7'b0000001; bus1.cp0_epc = 32'h80001234; #1;
    check("eret_pre_flush", 64'(bus1.flush), 64'h0);
    @(negedge clk);
    bus1.exc_flags = '0; #1;
    check("eret_flush", 64'(bus1.flush),    64'h1);
    check("eret_pc",    64'(bus1.exc_pc),   64'h80001234);
    check("eret_code",  64'(bus1.exc_code), 64'h0);
    check("eret_busy",  64'(bus1.busy),     64'h1);
    @(negedge clk); #1;
    check("eret_end_flush", 64'(bus1.flush),  64'h0);
    check("eret_end_pc",    64'(bus1.exc_pc), 64'hbfc00000);

    // Priority select; flag arriving during the flush is discarded
    @(negedge clk);
    bus1.exc_flags = 7'b0100100; #1;
    @(negedge clk);
    bus1.exc_flags = 7'b0000010; #1;
    check("prio_flush", 64'(bus1.flush),    64'h1);
    check("prio_code",  64'(bus1.exc_code), 64'h2);
    check("prio_pc",    64'(bus1.exc_pc),   64'hbfc00380);
    @(negedge clk);
    bus1.exc_flags = '0; #1;
    check("prio_no_second", 64'(bus1.flush), 64'h0);
    check("prio_idle",      64'(bus1.busy),  64'h0);
    @(negedge clk); #1;
    check("prio_still_idle", 64'(bus1.flush), 64'h0);

    // Deferred exception under stall_all for three cycles
    @(negedge clk);
    bus1.stall_all = 1'b1; bus1.exc_flags = 7'b0001000; #1;
    check("def_no_flush0", 64'(bus1.flush), 64'h0);
    @(negedge clk);
    bus1.exc_flags = 7'b0000001; #1;
    check("def_busy1",  64'(bus1.busy),  64'h1);
    check("def_flush1", 64'(bus1.flush), 64'h0);
    @(negedge clk); #1;
    check("def_flush2", 64'(bus1.flush), 64'h0);
    @(negedge clk);
    bus1.stall_all = 1'b0; #1;
    check("def_flush3", 64'(bus1.flush), 64'h0);
    check("def_busy3",  64'(bus1.busy),  64'h1);
    @(negedge clk);
    bus1.exc_flags = '0; #1;
    check("def_flush",  64'(bus1.flush),    64'h1);
    check("def_code",   64'(bus1.exc_code), 64'h3);
    check("def_pc",     64'(bus1.exc_pc),   64'hbfc00380);
    check("def_stall",  64'(bus1.stall),    64'h0);
    @(negedge clk); #1;
    check("def_end",    64'(bus1.flush),     64'h0);
    check("def_cnt",    64'(bus1.stall_cnt), 64'd8);

    // Three-cycle flush stretched by a stall_all pulse in its second cycle
    @(negedge clk);
    bus3.exc_flags = 7'b0000100; #1;
    @(negedge clk);
    bus3.exc_flags = '0; #1;
    check("f3_c1", 64'(bus3.flush), 64'h1);
    @(negedge clk);
    bus3.stall_all = 1'b1; #1;
    check("f3_c2",       64'(bus3.flush), 64'h1);
    check("f3_c2_stall", 64'(bus3.stall), 64'h3f);
    @(negedge clk);
    bus3.stall_all = 1'b0; #1;
    check("f3_c3",      64'(bus3.flush),    64'h1);
    check("f3_c3_code", 64'(bus3.exc_code), 64'h2);
    @(negedge clk); #1;
    check("f3_c4", 64'(bus3.flush), 64'h1);
    @(negedge clk); #1;
    check("f3_end", 64'(bus3.flush), 64'h0);

    // Asynchronous reset in the middle of a flush
    @(negedge clk);
    bus3.exc_flags = 7'b0000001; bus3.cp0_epc = 32'h80004444; #1;
    @(negedge clk);
    bus3.exc_flags = '0; #1;
    check("ar_flush_pre", 64'(bus3.flush),  64'h1);
    check("ar_pc_pre",    64'(bus3.exc_pc), 64'h80004444);
    rst = 1'b1; #1;
    check("ar_flush", 64'(bus3.flush),     64'h0);
    check("ar_pc",    64'(bus3.exc_pc),    64'hbfc00000);
    check("ar_busy",  64'(bus3.busy),      64'h0);
    check("ar_cnt",   64'(bus1.stall_cnt), 64'h0);
    @(negedge clk);
    rst = 1'b0; #1;
    @(negedge clk); #1;
    check("ar_dropped", 64'(bus3.flush), 64'h0);

    // Saturation of the stall counter from a preloaded value
    force dut1.stall_cnt_q = 32'hfffffffd;
    #1;
    release dut1.stall_cnt_q;
    #1;
    check("sat_preload", 64'(bus1.stall_cnt), 64'hfffffffd);
    bus1.stall_req = 6'b000001;
    @(negedge clk); #1;
    check("sat_fe", 64'(bus1.stall_cnt), 64'hfffffffe);
    @(negedge clk); #1;
    check("sat_ff", 64'(bus1.stall_cnt), 64'hffffffff);
    @(negedge clk); #1;
    check("sat_hold", 64'(bus1.stall_cnt), 64'hffffffff);
    bus1.stall_req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
